// File: rtl/intc_pkg.sv
// ============================================================================
// Module      : intc_pkg
// Description : Register offsets, VECTOR layout and priority helper for intc.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package intc_pkg;

    localparam logic [1:0] INTC_PENDING = 2'd0;
    localparam logic [1:0] INTC_MASK    = 2'd1;
    localparam logic [1:0] INTC_MODE    = 2'd2;
    localparam logic [1:0] INTC_VECTOR  = 2'd3;

    localparam int VEC_VALID_BIT = 31;
    localparam int ID_W          = 5;

    // Scanning downward leaves the lowest set index, which is the highest priority.
    function automatic logic [ID_W-1:0] lowest_id(input logic [31:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

`default_nettype wire

// File: rtl/intc_sync_edge.sv
// ============================================================================
// Module      : intc_sync_edge
// Description : Per-source synchroniser chain plus edge-history flop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module intc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
            r_hist  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], src};
            r_hist  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign s    = r_chain[SYNC_STAGES-1];
    assign rise = r_chain[SYNC_STAGES-1] & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/intc_ctrl.sv
// ============================================================================
// Module      : intc_ctrl
// Description : Bus-slave interrupt controller: pending/mask/mode, priority
//               vector and one registered CPU interrupt request.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module intc_ctrl
    import intc_pkg::*;
#(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [3:0]      be,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    // Registers are held at 32 bits; bits at or above NSRC are forced to zero.
    localparam logic [31:0] C_SRC_MASK = (NSRC >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << NSRC) - 32'd1);

    logic [31:0]     r_pending;
    logic [31:0]     r_mask;
    logic [31:0]     r_mode;
    logic            r_irq;

    logic [31:0]     w_s;
    logic [31:0]     w_rise;
    logic [31:0]     w_be_bits;
    logic [31:0]     w_wr_bits;
    logic [31:0]     w_clr;
    logic [31:0]     w_pend_next;
    logic [31:0]     w_act;
    logic            w_valid;
    logic [ID_W-1:0] w_id;
    logic            w_wr;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            intc_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk   (clk),
                .reset (reset),
                .src   (src[gi]),
                .s     (w_s[gi]),
                .rise  (w_rise[gi])
            );
        end
        if (NSRC < 32) begin : g_pad
            assign w_s[31:NSRC]    = '0;
            assign w_rise[31:NSRC] = '0;
        end
    endgenerate

    assign w_wr      = sel & we;
    assign w_be_bits = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign w_wr_bits = w_be_bits & C_SRC_MASK;
    assign w_clr     = (w_wr && addr == INTC_PENDING) ? (wdata & w_wr_bits) : '0;

    // Edge bits: a rise in the same cycle as a clear wins. Level bits follow s.
    assign w_pend_next = ((r_mode & (w_rise | (r_pending & ~w_clr))) |
                          (~r_mode & w_s)) & C_SRC_MASK;

    assign w_act   = r_pending & r_mask;
    assign w_valid = |w_act;
    assign w_id    = lowest_id(w_act);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_mode    <= C_SRC_MASK;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_irq     <= w_valid;
            if (w_wr && addr == INTC_MASK) begin
                r_mask <= (r_mask & ~w_wr_bits) | (wdata & w_wr_bits);
            end
            if (w_wr && addr == INTC_MODE) begin
                r_mode <= (r_mode & ~w_wr_bits) | (wdata & w_wr_bits);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            INTC_PENDING: rdata = r_pending;
            INTC_MASK:    rdata = r_mask;
            INTC_MODE:    rdata = r_mode;
            INTC_VECTOR: begin
                rdata[VEC_VALID_BIT] = w_valid;
                rdata[ID_W-1:0]      = w_id;
            end
            default:      rdata = '0;
        endcase
    end

    assign irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_intc_ctrl.sv
// ============================================================================
// Module      : tb_intc_ctrl
// Description : Directed, table-driven self-checking bench for intc_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_intc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  src;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_cmp;
    int n_fail;

    intc_ctrl #(
        .NSRC        (6),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  src;
        logic        wr;
        logic [1:0]  waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [5:0] s, input logic w, input logic [1:0] wa,
                                input logic [3:0] b, input logic [31:0] wd,
                                input logic [1:0] ra, input logic [31:0] er, input logic ei);
        vec_t v;
        v.src = s; v.wr = w; v.waddr = wa; v.be = b; v.wdata = wd;
        v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, then read back raddr just after the edge.
    task automatic step(input logic [5:0] s, input logic w, input logic [1:0] wa,
                        input logic [3:0] b, input logic [31:0] wd, input logic [1:0] ra);
        @(negedge clk);
        src = s; sel = w; we = w; addr = wa; be = b; wdata = wd;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; addr = ra;
        #1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; src = '0; sel = 1'b0; we = 1'b0; addr = 2'd0; be = 4'h0; wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        addr = 2'd0; #1 check32("rst_pending", rdata, 32'h0);
        addr = 2'd1; #1 check32("rst_mask",    rdata, 32'h0);
        addr = 2'd2; #1 check32("rst_mode",    rdata, 32'h3F);
        addr = 2'd3; #1 check32("rst_vector",  rdata, 32'h0);
        check32("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Edge latency, W1C
        tbl[0]  = mk(6'h00, 1, 2'd1, 4'hF, 32'h3F,       2'd1, 32'h0000_003F, 0);
        tbl[1]  = mk(6'h04, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         0);
        tbl[2]  = mk(6'h04, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         0);
        tbl[3]  = mk(6'h04, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h04,        0);
        tbl[4]  = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd3, 32'h8000_0002, 1);
        tbl[5]  = mk(6'h00, 1, 2'd0, 4'hF, 32'h04,       2'd0, 32'h0,         1);
        tbl[6]  = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         0);
        // Masking and priority
        tbl[7]  = mk(6'h00, 1, 2'd1, 4'hF, 32'h30,       2'd1, 32'h30,        0);
        tbl[8]  = mk(6'h12, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         0);
        tbl[9]  = mk(6'h12, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         0);
        tbl[10] = mk(6'h12, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h12,        0);
        tbl[11] = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd3, 32'h8000_0004, 1);
        tbl[12] = mk(6'h00, 1, 2'd1, 4'hF, 32'h32,       2'd3, 32'h8000_0001, 1);
        tbl[13] = mk(6'h00, 1, 2'd1, 4'hF, 32'h00,       2'd3, 32'h0,         1);
        tbl[14] = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h12,        0);
        // Level mode: MODE change keeps PENDING until the next edge
        tbl[15] = mk(6'h00, 1, 2'd2, 4'hF, 32'h00,       2'd0, 32'h12,        0);
        tbl[16] = mk(6'h01, 1, 2'd1, 4'hF, 32'h01,       2'd0, 32'h0,         0);
        tbl[17] = mk(6'h01, 0, 2'd0, 4'h0, 32'h0,        2'd2, 32'h0,         0);
        tbl[18] = mk(6'h01, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h01,        0);
        tbl[19] = mk(6'h01, 1, 2'd0, 4'hF, 32'h01,       2'd0, 32'h01,        1);
        tbl[20] = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h01,        1);
        tbl[21] = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h01,        1);
        tbl[22] = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         1);
        tbl[23] = mk(6'h00, 0, 2'd0, 4'h0, 32'h0,        2'd0, 32'h0,         0);
        // Byte enables, VECTOR write ignored, back to edge mode
        tbl[24] = mk(6'h00, 1, 2'd1, 4'h0, 32'hFFFF_FFFF, 2'd1, 32'h01,       0);
        tbl[25] = mk(6'h00, 1, 2'd1, 4'h1, 32'hFFFF_FFFF, 2'd1, 32'h3F,       0);
        tbl[26] = mk(6'h00, 1, 2'd2, 4'hF, 32'hFFFF_FFFF, 2'd2, 32'h3F,       0);
        tbl[27] = mk(6'h00, 1, 2'd3, 4'hF, 32'hFFFF_FFFF, 2'd3, 32'h0,        0);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].src, tbl[i].wr, tbl[i].waddr, tbl[i].be, tbl[i].wdata, tbl[i].raddr);
            check32($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            check32($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
        end

        // Set/clear collision: W1C of bit 3 on the edge where rise[3]=1
        step(6'h08, 0, 2'd0, 4'h0, 32'h0,  2'd0);
        step(6'h08, 0, 2'd0, 4'h0, 32'h0,  2'd0);
        step(6'h08, 1, 2'd0, 4'hF, 32'h08, 2'd0);
        check32("collide_set_wins", rdata, 32'h08);
        step(6'h00, 1, 2'd0, 4'hF, 32'h08, 2'd0);
        check32("collide_clear_after", rdata, 32'h0);

        // Asynchronous reset mid-run with PENDING=0x05
        step(6'h05, 0, 2'd0, 4'h0, 32'h0, 2'd0);
        step(6'h05, 0, 2'd0, 4'h0, 32'h0, 2'd0);
        step(6'h05, 0, 2'd0, 4'h0, 32'h0, 2'd0);
        check32("pre_async_pending", rdata, 32'h05);
        reset = 1'b1;
        #0.5;
        check32("async_pending", rdata, 32'h0);
        addr = 2'd1;
        #0.2;
        check32("async_mask", rdata, 32'h0);
        check32("async_irq", {31'd0, irq}, 32'd0);
        #0.3;
        reset = 1'b0;
        src = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
